// File: rtl/tiger_muldiv_seq.sv
// tiger_muldiv_seq: iterative HI/LO mul/div sequencer; TIGER_MULDIV_EARLY_TERM_EN enables multiply early termination
module tiger_muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] srca,
  input  logic [DATA_WIDTH-1:0] srcb,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div, neg_res, neg_rem;
  logic [2*W-1:0]  mc, acc, acc_mul, acc_div, res_mul;
  logic [W-1:0]    mp, a_mag, b_mag, quo, rem, q_fix, r_fix;
  logic [W:0]      trial, diff;
  logic            signed_op, qbit, last, dz;
  // operand magnitudes, one shift-add / restoring-subtract step, and the final sign fixup
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && srca[W-1]) ? -srca : srca;
    b_mag     = (signed_op && srcb[W-1]) ? -srcb : srcb;
    acc_mul   = acc + (mp[0] ? mc : '0);
    trial     = acc[2*W-1:W-1];
    diff      = trial - {1'b0, mp};
    qbit      = trial >= {1'b0, mp};
    acc_div   = {qbit ? diff[W-1:0] : trial[W-1:0], acc[W-2:0], qbit};
    quo       = acc[W-1:0];
    rem       = acc[2*W-1:W];
    dz        = mp == '0;
    q_fix     = dz ? '1 : (neg_res ? -quo : quo);
    r_fix     = neg_rem ? -rem : rem;
    res_mul   = neg_res ? -acc : acc;
`ifdef TIGER_MULDIV_EARLY_TERM_EN
    last      = (cnt == CW'(W-1)) || (!is_div && mp[W-1:1] == '0);
`else
    last      = cnt == CW'(W-1);
`endif
  end
  // sequencer: IDLE accepts requests and MTHI/MTLO, RUN iterates, FIX commits hi/lo
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      mc      <= '0;
      mp      <= '0;
      acc     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start && !flush) begin
            if (!op[2]) begin
              state   <= RUN;
              busy    <= 1'b1;
              is_div  <= op[1];
              neg_res <= signed_op & (srca[W-1] ^ srcb[W-1]);
              neg_rem <= signed_op & srca[W-1];
              mc      <= {{W{1'b0}}, a_mag};
              mp      <= b_mag;
              acc     <= op[1] ? {{W{1'b0}}, a_mag} : '0;
              cnt     <= '0;
            end else if (op[1:0] == 2'd0) hi <= srca;
            else if (op[1:0] == 2'd1) lo <= srca;
          end
        RUN:
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc   <= is_div ? acc_div : acc_mul;
            mc    <= mc << 1;
            mp    <= is_div ? mp : mp >> 1;
            cnt   <= cnt + CW'(1);
            state <= last ? FIX : RUN;
          end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            {hi, lo} <= is_div ? {r_fix, q_fix} : res_mul;
            done     <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_tiger_muldiv_seq.sv
// tb_tiger_muldiv_seq: scoreboard bench for the HI/LO mul/div sequencer
module tb_tiger_muldiv_seq;
  logic        clk, reset, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] srca, srcb, hi, lo;
  int          checks, errors;
  logic [63:0] sbq[$];

  tiger_muldiv_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 3'd0) return sa * sb;
    if (o == 3'd1) return {32'b0, a} * {32'b0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd3) return {a % b, a / b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
    int n;
    n = 32;
`ifdef TIGER_MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      logic [31:0] m;
      m = (o == 3'd0 && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`else
    if (o[2] && b[0]) n = 32;
`endif
    return n + 2;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
    int cyc, bad;
    logic [63:0] exp;
    sbq.push_back(model(o, a, b));
    issue(o, a, b);
    cyc = 1;
    bad = 0;
    while (!done && cyc < 100) begin
      if (!busy) bad++;
      start = (cyc == poke);
      if (cyc == poke) begin op = 3'd3; srca = 32'd99; srcb = 32'd4; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("busy_run", 64'(bad), 64'd0);
    chk("latency", 64'(cyc), 64'(exp_lat(o, b)));
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    exp = sbq.pop_front();
    chk("hi", {32'd0, hi}, {32'd0, exp[63:32]});
    chk("lo", {32'd0, lo}, {32'd0, exp[31:0]});
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
  endtask

  task automatic flush_at(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int fc);
    logic [63:0] prev;
    int seen;
    prev = {hi, lo};
    issue(o, a, b);
    for (int c = 1; c < fc; c++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("flush_done", 64'(seen), 64'd0);
    chk("flush_hilo", {hi, lo}, prev);
  endtask

  initial begin
    checks = 0; errors = 0;
    start = 0; op = 0; srca = 0; srcb = 0; flush = 0; reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 0;
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(3'd3, 32'd100, 32'd7, 0);
    run(3'd3, 32'h1234, 32'd0, 0);
    chk("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run(3'd2, 32'hFFFF_FF00, 32'd0, 0);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_wrap", {hi, lo}, 64'h0000_0000_8000_0000);
    run(3'd1, 32'd5, 32'd3, 0);
    run(3'd1, 32'd5, 32'd0, 0);
    run(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    @(negedge clk);
    start = 1; op = 3'd4; srca = 32'hA5A5_A5A5;
    @(negedge clk);
    start = 0;
    chk("mthi", {32'd0, hi}, 64'hA5A5_A5A5);
    chk("mthi_busy", {62'd0, busy, done}, 64'd0);
    start = 1; op = 3'd5; srca = 32'h5A5A_5A5A;
    @(negedge clk);
    start = 0;
    chk("mtlo", {32'd0, lo}, 64'h5A5A_5A5A);
    chk("mtlo_busy", {62'd0, busy, done}, 64'd0);
    start = 1; op = 3'd4; srca = 32'h1111_1111; flush = 1;
    @(negedge clk);
    start = 0; flush = 0;
    chk("flush_start_idle", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
    start = 1; op = 3'd6; srca = 32'h2222_2222;
    @(negedge clk);
    start = 0;
    chk("nop_busy", {63'd0, busy}, 64'd0);
    chk("nop_hilo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
    flush_at(3'd3, 32'd1000, 32'd3, 10);
    chk("flush_keep", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
    flush_at(3'd2, 32'd77, 32'd5, 33);
    run(3'd1, 32'h0001_0003, 32'h0002_0005, 5);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
      run(o, a, b, 0);
    end
    run(3'd3, 32'd100, 32'd7, 0);
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (19) @(negedge clk);
    reset = 1;
    #1;
    chk("async_rst_busy", {62'd0, busy, done}, 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 0;
    run(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
